calc_engine: RTL

CALC_ENGINE -- requirements
Module: calc_engine

---
 rtl/calc_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/calc_engine.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator engine and its display.
package calc_pkg;

    // Operation select as carried on the func input.
    typedef enum logic [2:0] {
        FUNC_ADD = 3'b000,
        FUNC_SUB = 3'b001,
        FUNC_MUL = 3'b010,
        FUNC_DIV = 3'b011,
        FUNC_AND = 3'b100,
        FUNC_OR  = 3'b101,
        FUNC_XOR = 3'b110,
        FUNC_SHL = 3'b111
    } func_t;

    // Control states of the engine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Index of the last iteration of the 8-step multiply/divide.
    localparam logic [2:0] ITER_LAST = 3'd7;

    // Result reported for a divide by zero.
    localparam logic [31:0] DIV0_RESULT = '1;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter.
// btn_rise is a one-cycle pulse issued together with a 0->1 level change.
module btn_debounce #(
    parameter logic [19:0] DEBOUNCE_CNT = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);

    logic        sync1;
    logic        sync2;
    logic [19:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    // Accept a new level once it has differed for DEBOUNCE_CNT cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
        end else begin
            btn_rise <= 1'b0;
            if (sync2 == btn_level) begin
                cnt <= '0;
            end else if (cnt >= DEBOUNCE_CNT - 20'd1) begin
                cnt       <= '0;
                btn_level <= sync2;
                btn_rise  <= sync2;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/calc_engine.sv
// Button-triggered 8-bit calculator: single-cycle logic/add/sub/shift,
// 8-step shift-add multiply and 8-step restoring divide.
module calc_engine
    import calc_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CNT = 20'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [2:0]  func,
    input  logic [7:0]  num1,
    input  logic [7:0]  num2,
    output logic [31:0] cal_result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    logic        btn_level;
    logic        btn_rise;
    logic        press;

    state_t      state;
    func_t       func_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [2:0]  iter;
    logic [15:0] acc;
    logic [7:0]  rem;
    logic [7:0]  quo;
    logic [7:0]  dvd;

    logic        calc_done;
    logic        div_zero;
    logic [31:0] result_next;
    logic [15:0] mul_acc_next;
    logic [8:0]  div_trial;
    logic        div_ge;
    logic [7:0]  div_rem_next;
    logic [7:0]  div_quo_next;

    btn_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (button),
        .btn_level(btn_level),
        .btn_rise (btn_rise)
    );

    // A press is a debounced rise; the level qualifier guards against a stale pulse.
    assign press = btn_rise & btn_level;

    // Next-step datapath values and completion decision for the current CALC cycle.
    always_comb begin
        calc_done    = 1'b0;
        div_zero     = 1'b0;
        result_next  = '0;
        mul_acc_next = acc + (b_q[iter] ? ({8'b0, a_q} << iter) : 16'd0);
        div_trial    = {rem, dvd[7]};
        div_ge       = (div_trial >= {1'b0, b_q});
        div_rem_next = div_ge ? 8'(div_trial - {1'b0, b_q}) : div_trial[7:0];
        div_quo_next = {quo[6:0], div_ge};
        case (func_q)
            FUNC_ADD: begin
                calc_done   = 1'b1;
                result_next = {24'b0, a_q} + {24'b0, b_q};
            end
            FUNC_SUB: begin
                calc_done   = 1'b1;
                result_next = {24'b0, a_q} - {24'b0, b_q};
            end
            FUNC_MUL: begin
                calc_done   = (iter == ITER_LAST);
                result_next = {16'b0, mul_acc_next};
            end
            FUNC_DIV: begin
                if (b_q == 8'd0) begin
                    calc_done   = 1'b1;
                    div_zero    = 1'b1;
                    result_next = DIV0_RESULT;
                end else begin
                    calc_done   = (iter == ITER_LAST);
                    result_next = {8'b0, div_quo_next, 8'b0, div_rem_next};
                end
            end
            FUNC_AND: begin
                calc_done   = 1'b1;
                result_next = {24'b0, a_q & b_q};
            end
            FUNC_OR: begin
                calc_done   = 1'b1;
                result_next = {24'b0, a_q | b_q};
            end
            FUNC_XOR: begin
                calc_done   = 1'b1;
                result_next = {24'b0, a_q ^ b_q};
            end
            FUNC_SHL: begin
                calc_done   = 1'b1;
                result_next = {24'b0, a_q} << b_q[4:0];
            end
            default: begin
                calc_done   = 1'b1;
                result_next = '0;
            end
        endcase
    end

    // Control FSM with registered outputs and iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cal_result <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            func_q     <= FUNC_ADD;
            a_q        <= '0;
            b_q        <= '0;
            iter       <= '0;
            acc        <= '0;
            rem        <= '0;
            quo        <= '0;
            dvd        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (press) begin
                        state  <= ST_CALC;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        func_q <= func_t'(func);
                        a_q    <= num1;
                        b_q    <= num2;
                        iter   <= '0;
                        acc    <= '0;
                        rem    <= '0;
                        quo    <= '0;
                        dvd    <= num1;
                    end
                end
                ST_CALC: begin
                    // Multiply and divide registers step together; only the selected one is used.
                    iter <= iter + 3'd1;
                    acc  <= mul_acc_next;
                    rem  <= div_rem_next;
                    quo  <= div_quo_next;
                    dvd  <= {dvd[6:0], 1'b0};
                    if (calc_done) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        cal_result <= result_next;
                        err        <= div_zero;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
